uart_rx: RTL and testbench

//  8N1 UART receiver; counterpart of the UART transmitter on the same serial link.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers.
// Used by both the receiver and the transmitter on the same serial link.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud_rate);
    return clk_hz / baud_rate;
  endfunction

  // Bits needed to count 0..clks_per_bit-1, never less than one.
  function automatic int calc_timer_width(input int clks_per_bit);
    int w;
    w = 1;
    while ((1 << w) < clks_per_bit) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RESET_VAL so an idle-high line does not look active after reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, valid/ready byte output
// with frame-error and overrun pulses.
module uart_rx #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  input  logic       i_rx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_frame_err,
  output logic       o_rx_overrun
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int TIMER_W      = calc_timer_width(CLKS_PER_BIT);

  localparam logic [TIMER_W-1:0] C_BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] C_HALF_LAST = TIMER_W'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);
  localparam logic [TIMER_W-1:0] C_ONE       = TIMER_W'(1);

  logic               w_rxd_s;
  logic               w_bit_done;
  logic               w_half_done;

  uart_state_t        r_state;
  logic [TIMER_W-1:0] r_timer;
  logic [2:0]         r_bit_index;
  logic [7:0]         r_shift;
  logic               r_deliver;
  logic               r_frame_err;
  logic               r_rx_valid;
  logic [7:0]         r_rx_data;
  logic               r_overrun;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rxd),
    .o_q   (w_rxd_s)
  );

  assign w_bit_done  = (r_timer == C_BIT_LAST);
  assign w_half_done = (r_timer == C_HALF_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_bit_index <= '0;
      r_shift     <= '0;
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (!w_rxd_s) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          // Start bit must still be low at its centre, otherwise it was a glitch.
          if (w_half_done) begin
            r_timer     <= '0;
            r_bit_index <= '0;
            r_state     <= w_rxd_s ? ST_IDLE : ST_DATA;
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end
        ST_DATA: begin
          if (w_bit_done) begin
            r_timer <= '0;
            r_shift <= {w_rxd_s, r_shift[7:1]};
            if (r_bit_index == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_index <= r_bit_index + 3'd1;
            end
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end
        ST_STOP: begin
          if (w_bit_done) begin
            r_timer <= '0;
            if (w_rxd_s) begin
              r_deliver <= 1'b1;
              r_state   <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end else begin
            r_timer <= r_timer + C_ONE;
          end
        end
        ST_BREAK: begin
          // A held-low line is a break, not a stream of zero bytes.
          r_timer <= '0;
          if (w_rxd_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_deliver) begin
        // A byte arriving while the previous one is still unconsumed is dropped.
        if (!r_rx_valid || i_rx_ready) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_rx_valid     = r_rx_valid;
  assign o_rx_data      = r_rx_data;
  assign o_rx_frame_err = r_frame_err;
  assign o_rx_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of single frames plus hand-written
// sequences for glitch, overrun, mid-frame reset and back-to-back frames.
module tb_uart_rx;

  localparam int P = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_overrun;

  always #5 clk = ~clk;

  uart_rx dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rxd          (rxd),
    .i_rx_ready     (rx_ready),
    .o_rx_valid     (rx_valid),
    .o_rx_data      (rx_data),
    .o_rx_frame_err (rx_frame_err),
    .o_rx_overrun   (rx_overrun)
  );

  // Monitor: cumulative event counters, sampled between edges.
  int         m_valid_cyc = 0;
  int         m_ferr = 0;
  int         m_ovr = 0;
  logic [7:0] acc_q[$];

  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      if (rx_valid) m_valid_cyc++;
      if (rx_valid && rx_ready) acc_q.push_back(rx_data);
      if (rx_frame_err) m_ferr++;
      if (rx_overrun) m_ovr++;
    end
  end

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic stop_bit);
    rxd = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (p) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (p) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  typedef struct {
    logic [7:0] data;
    int         period;
    logic       stop_bit;
    int         exp_acc;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  int a0, v0, f0, o0;

  initial begin
    vecs[0] = '{8'hA5, 434, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 434, 1'b0, 0, 1};
    vecs[2] = '{8'h81, 434, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 421, 1'b1, 1, 0};
    vecs[4] = '{8'h55, 447, 1'b1, 1, 0};

    // Reset state
    repeat (5) @(negedge clk);
    #1;
    check("reset_valid", int'(rx_valid), 0);
    check("reset_data", int'(rx_data), 0);
    check("reset_ferr", int'(rx_frame_err), 0);
    check("reset_ovr", int'(rx_overrun), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    // Table of single frames with rx_ready held high
    for (int i = 0; i < 5; i++) begin
      a0 = acc_q.size(); v0 = m_valid_cyc; f0 = m_ferr; o0 = m_ovr;
      send_frame(vecs[i].data, vecs[i].period, vecs[i].stop_bit);
      idle(20);
      $display("vector %0d: data=0x%0h period=%0d stop=%0d", i, vecs[i].data,
               vecs[i].period, vecs[i].stop_bit);
      check("vec_accepted", acc_q.size() - a0, vecs[i].exp_acc);
      check("vec_valid_cycles", m_valid_cyc - v0, vecs[i].exp_acc);
      check("vec_frame_err", m_ferr - f0, vecs[i].exp_ferr);
      check("vec_overrun", m_ovr - o0, 0);
      if (vecs[i].exp_acc == 1 && acc_q.size() > a0)
        check("vec_data", int'(acc_q[acc_q.size()-1]), int'(vecs[i].data));
    end

    // Short low glitch on idle line
    a0 = acc_q.size(); v0 = m_valid_cyc; f0 = m_ferr;
    rxd = 1'b0;
    repeat (100) @(negedge clk);
    rxd = 1'b1;
    idle(P);
    check("glitch_valid_cycles", m_valid_cyc - v0, 0);
    check("glitch_ferr", m_ferr - f0, 0);
    check("glitch_valid_now", int'(rx_valid), 0);

    // Blocked consumer: second byte overruns, first one retained
    rx_ready = 1'b0;
    a0 = acc_q.size(); o0 = m_ovr;
    send_frame(8'h11, P, 1'b1);
    send_frame(8'h22, P, 1'b1);
    idle(20);
    check("ovr_valid_held", int'(rx_valid), 1);
    check("ovr_data_held", int'(rx_data), 8'h11);
    check("ovr_pulse", m_ovr - o0, 1);
    check("ovr_none_accepted", acc_q.size() - a0, 0);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    #3;
    check("ovr_valid_cleared", int'(rx_valid), 0);
    check("ovr_accepted", acc_q.size() - a0, 1);
    if (acc_q.size() > a0)
      check("ovr_accepted_data", int'(acc_q[acc_q.size()-1]), 8'h11);

    // Reset during bit 4 of 0xF0, with a pending byte on the output
    rx_ready = 1'b0;
    send_frame(8'h77, P, 1'b1);
    idle(20);
    check("pre_rst_valid", int'(rx_valid), 1);
    check("pre_rst_data", int'(rx_data), 8'h77);
    f0 = m_ferr;
    fork
      send_frame(8'hF0, P, 1'b1);
      begin
        repeat (5 * P + P / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_valid", int'(rx_valid), 0);
        check("rst_mid_data", int'(rx_data), 0);
        check("rst_mid_ferr", int'(rx_frame_err), 0);
        check("rst_mid_ovr", int'(rx_overrun), 0);
        rst = 1'b0;
      end
    join
    rx_ready = 1'b1;
    idle(20);
    a0 = acc_q.size(); v0 = m_valid_cyc;
    check("post_rst_valid", int'(rx_valid), 0);
    send_frame(8'h5A, P, 1'b1);
    idle(20);
    check("post_rst_accepted", acc_q.size() - a0, 1);
    check("post_rst_valid_cycles", m_valid_cyc - v0, 1);
    check("post_rst_ferr", m_ferr - f0, 0);
    if (acc_q.size() > a0)
      check("post_rst_data", int'(acc_q[acc_q.size()-1]), 8'h5A);

    // Back-to-back 0x00 then 0xFF
    a0 = acc_q.size(); f0 = m_ferr; o0 = m_ovr;
    send_frame(8'h00, P, 1'b1);
    send_frame(8'hFF, P, 1'b1);
    idle(20);
    check("b2b_accepted", acc_q.size() - a0, 2);
    check("b2b_ferr", m_ferr - f0, 0);
    check("b2b_ovr", m_ovr - o0, 0);
    if (acc_q.size() >= a0 + 2) begin
      check("b2b_first", int'(acc_q[a0]), 8'h00);
      check("b2b_second", int'(acc_q[a0+1]), 8'hFF);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
